fifo_drain: RTL
===============

# fifo_drain

Downstream consumer of the synchronous FIFO. It issues FIFO reads, absorbs the FIFO's one-cycle registered read latency in a 2-entry output buffer, and presents the words as a valid/ready stream framed into fixed-length packets. It also counts and discards reads the FIFO flags as underflow.

## Interface
Parameters:
- DATA_WIDTH, 16, word width; must match the FIFO's DATA_WIDTH.
- PKT_LEN, 4, words per packet; m_last marks every PKT_LEN-th word. Legal range ≥1.
- DROP_WIDTH, 8, width of the saturating drop counter.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = drain the FIFO; 0 = stop issuing reads and finish in-flight work.
- fifo_read_en  out  1  read strobe to the FIFO.
- fifo_data_out  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_read_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_underflow  in  1  FIFO underflow pulse; arrives in the same cycle as the read data.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WIDTH  output word.
- m_last  out  1  last word of the current packet; qualified by m_valid.
- busy  out  1  state ≠ IDLE, or a read is in flight, or the buffer is non-empty.
- drop_count  out  DROP_WIDTH  number of underflowed reads; saturates at all-ones.

## Operation
- FSM states:
  - IDLE: goes to RUN when enable=1.
  - RUN: goes to DRAIN when enable=0.
  - DRAIN: goes to IDLE once no read is in flight and the buffer is empty; goes back to RUN if enable=1.
- Read issue:
  - fifo_read_en = (state==RUN) && !fifo_empty && (occ + inflight − pop ≤ 1).
  - occ is buffer occupancy, 0..2.
  - inflight is the read issued last cycle, 0..1.
  - pop = m_valid && m_ready.
  - fifo_read_en is combinational.
- Read return: one cycle after fifo_read_en, the word is pushed into the buffer unless fifo_underflow=1 in that cycle.
- Underflow: on fifo_underflow=1, discard the word and increment drop_count by 1, saturating. No buffer push.
- Output buffer: 2-entry FIFO ordering, push and pop in the same cycle allowed.
  - m_valid = (occ ≠ 0).
  - m_data = head entry.
- Framing:
  - word_idx counts 0..PKT_LEN−1 and advances only on a handshake (m_valid && m_ready).
  - word_idx wraps to 0 after PKT_LEN−1.
  - m_last = m_valid && (word_idx == PKT_LEN−1).
  - With PKT_LEN=1, m_last equals m_valid.
- Holding: while m_valid=1 && m_ready=0, m_data and m_last stay stable.
- Leaving RUN: word_idx is not reset when the FSM leaves RUN; packets span enable gaps.
- Reset, including mid-operation: synchronous.
  - Clears FSM to IDLE, occ, inflight, word_idx and drop_count.
  - In-flight and buffered data are discarded.
  - Output reset values: fifo_read_en=0, m_valid=0, m_data=0, m_last=0, busy=0, drop_count=0.

## Timing
- Latency from a fifo_read_en cycle to m_valid: 2 cycles; the data registers in the FIFO, then pushes into the buffer.
- Sustained throughput: 1 word/cycle while m_ready=1 and the FIFO is non-empty.
- Backpressure: with m_ready=0, at most 2 reads are outstanding (buffer + in-flight). No read is issued that could overflow the buffer.
- fifo_empty is treated as advisory. Reads the FIFO reports as underflow are absorbed, never forwarded.
- DRAIN: last fifo_read_en is in the cycle enable falls, at the latest. DRAIN→IDLE occurs in the cycle after the final pop.
- All state updates occur on the rising edge of clk.

## Structure
- Shared package fifo_pkg:
  - state typedef drain_state_t {IDLE, RUN, DRAIN};
  - default DATA_WIDTH constant.
- Sub-module fifo_skid_buf: the 2-entry buffer. It has push/pop/data ports, occ output and synchronous active-high reset.
- Top level: FSM, read-issue logic, framing counter, drop counter.

## Test plan
- Basic drain: FIFO preloaded with 0x0001..0x0008, enable=1, m_ready=1 → m_data 0x0001..0x0008 on consecutive cycles; m_last on 0x0004 and 0x0008; first m_valid 2 cycles after the first fifo_read_en.
- Backpressure: 6 words queued, m_ready=0 for 10 cycles → exactly 2 reads issued and m_data=first word held stable; then m_ready=1 → remaining words delivered in order with no gap.
- Underflow: fifo_underflow pulsed on 3 returned reads → those words absent from the stream; drop_count=3. Then force 300 underflows → drop_count=0xFF.
- Enable gap: drop enable after 2 words of a packet → FSM DRAIN→IDLE, busy falls after the last pop; re-enable → next words continue as idx 2,3 and m_last is on the 4th word overall.
- Reset mid-packet: reset asserted with occ=2 and a read in flight → next cycle m_valid=0, drop_count=0, busy=0; restart yields m_last on the 4th word after reset.
- PKT_LEN=1 variant: every accepted word has m_last=1.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared types and constants for the FIFO drain path.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } drain_state_t;

    localparam int c_default_data_width = 16;

    // Counter width for 0..n-1; never zero so a one-word packet still has a register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_skid_buf
//  Description : Two-entry in-order buffer with simultaneous push and pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = c_default_data_width
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [1:0]            occ_o
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            occ_q, occ_d;
    logic                  pop_eff;

    assign pop_eff = pop_i && (occ_q != 2'd0);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push_i, pop_eff})
            2'b10: begin
                if (occ_q != 2'd2) begin
                    if (occ_q == 2'd0) begin
                        head_d = data_i;
                    end else begin
                        tail_d = data_i;
                    end
                    occ_d = occ_q + 2'd1;
                end
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is unchanged; the incoming word lands behind whatever remains.
                if (occ_q == 2'd1) begin
                    head_d = data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign data_o = head_q;
    assign occ_o  = occ_q;

endmodule
`default_nettype wire

// File: rtl/fifo_drain.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_drain
//  Description : Reads a synchronous FIFO and emits a packet-framed valid/ready stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = c_default_data_width,
    parameter int PKT_LEN    = 4,
    parameter int DROP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  fifo_read_en,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic [DROP_WIDTH-1:0] drop_count
);

    localparam int                 c_idx_w    = idx_width(PKT_LEN);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(PKT_LEN - 1);

    drain_state_t          state_q;
    logic                  inflight_q;
    logic [c_idx_w-1:0]    word_idx_q, word_idx_d;
    logic [DROP_WIDTH-1:0] drop_q, drop_d;
    logic [1:0]            occ;
    logic                  pop;
    logic                  push;

    assign pop  = m_valid && m_ready;
    assign push = inflight_q && !fifo_underflow;

    // occ + inflight - pop <= 1, rearranged to avoid a negative intermediate.
    assign fifo_read_en = (state_q == RUN) && !fifo_empty &&
                          (({1'b0, occ} + {2'b00, inflight_q}) <= (3'd1 + {2'b00, pop}));

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk    (clk),
        .reset  (reset),
        .push_i (push),
        .pop_i  (pop),
        .data_i (fifo_data_out),
        .data_o (m_data),
        .occ_o  (occ)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (enable) state_q <= RUN;
                RUN:     if (!enable) state_q <= DRAIN;
                DRAIN: begin
                    if (enable) begin
                        state_q <= RUN;
                    end else if (!inflight_q && (occ == 2'd0)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        word_idx_d = word_idx_q;
        if (pop) begin
            word_idx_d = (word_idx_q == c_last_idx) ? '0 : word_idx_q + 1'b1;
        end
        drop_d = drop_q;
        if (inflight_q && fifo_underflow && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= 1'b0;
            word_idx_q <= '0;
            drop_q     <= '0;
        end else begin
            inflight_q <= fifo_read_en;
            word_idx_q <= word_idx_d;
            drop_q     <= drop_d;
        end
    end

    assign m_valid    = (occ != 2'd0);
    assign m_last     = m_valid && (word_idx_q == c_last_idx);
    assign busy       = (state_q != IDLE) || inflight_q || (occ != 2'd0);
    assign drop_count = drop_q;

endmodule
`default_nettype wire
